// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: writeback-select encodings, register index width,
// and data-memory sizing defaults used by the MEM stage and its memory.
`timescale 1ns/1ps
package pipeline_pkg;
    localparam int DMEM_WORDS_DEF = 256;
    localparam int ADDR_BITS_DEF  = 8;
    localparam int REG_IDX_W      = 4;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_NPC = 2'b10;
endpackage

// File: rtl/data_memory.sv
// Single-port word-addressed data memory: synchronous write, asynchronous read.
// Contents are never reset.
`timescale 1ns/1ps
module data_memory #(
    parameter int WORDS     = 256,
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata
);
    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    // Read sees pre-write contents during a same-cycle store.
    assign rdata = mem[addr];
endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory access, writeback-value selection and the
// MEM/WB pipeline register, plus a sticky access-fault flag.
`timescale 1ns/1ps
module mem_stage
    import pipeline_pkg::*;
#(
    parameter int DMEM_WORDS = DMEM_WORDS_DEF,
    parameter int ADDR_BITS  = ADDR_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 RegWr_EX,
    input  logic                 MemWr_EX,
    input  logic                 MemRd_EX,
    input  logic [1:0]           WBdata_EX,
    input  logic [31:0]          ALUout_EX,
    input  logic [31:0]          D,
    input  logic [31:0]          npc3,
    input  logic [REG_IDX_W-1:0] rd3,
    input  logic                 RPzero_EX,
    output logic [31:0]          Fwd_MEM,
    output logic                 RegWr_WB,
    output logic [REG_IDX_W-1:0] Rd_WB,
    output logic                 RPzero_WB,
    output logic [31:0]          WB_data,
    output logic                 mem_fault
);
    logic                 addr_ok_p0;
    logic                 live_p0;
    logic                 mem_we_p0;
    logic                 fault_p0;
    logic [ADDR_BITS-1:0] word_idx_p0;
    logic [31:0]          rdata_p0;
    logic [31:0]          ld_data_p0;

    logic                 regwr_p1;
    logic [REG_IDX_W-1:0] rd_p1;
    logic                 rpzero_p1;
    logic [31:0]          wb_data_p1;
    logic                 fault_p1;

    // Stage p0: address check, memory access and forwarding mux (combinational)
    assign addr_ok_p0  = (ALUout_EX[1:0] == 2'b00) &&
                         ((ALUout_EX >> (ADDR_BITS + 2)) == 32'd0);
    assign word_idx_p0 = ALUout_EX[ADDR_BITS+1:2];
    assign live_p0     = ~RPzero_EX;
    // Stores are held off while reset is asserted so memory survives reset.
    assign mem_we_p0   = MemWr_EX & live_p0 & addr_ok_p0 & reset;
    assign fault_p0    = (MemWr_EX | MemRd_EX) & live_p0 & ~addr_ok_p0;

    data_memory #(
        .WORDS     (DMEM_WORDS),
        .ADDR_BITS (ADDR_BITS)
    ) u_dmem (
        .clk   (clk),
        .we    (mem_we_p0),
        .addr  (word_idx_p0),
        .wdata (D),
        .rdata (rdata_p0)
    );

    always_comb begin
        ld_data_p0 = 32'd0;
        if (MemRd_EX && live_p0 && addr_ok_p0) ld_data_p0 = rdata_p0;
    end

    always_comb begin
        Fwd_MEM = ALUout_EX;
        case (WBdata_EX)
            WB_ALU:  Fwd_MEM = ALUout_EX;
            WB_MEM:  Fwd_MEM = ld_data_p0;
            WB_NPC:  Fwd_MEM = npc3;
            default: Fwd_MEM = ALUout_EX;
        endcase
    end

    // Stage p1: MEM/WB pipeline register and sticky fault
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regwr_p1   <= 1'b0;
            rd_p1      <= '0;
            rpzero_p1  <= 1'b0;
            wb_data_p1 <= 32'd0;
            fault_p1   <= 1'b0;
        end else begin
            regwr_p1   <= RegWr_EX & ~RPzero_EX;
            rd_p1      <= rd3;
            rpzero_p1  <= RPzero_EX;
            wb_data_p1 <= Fwd_MEM;
            if (fault_p0) fault_p1 <= 1'b1;
        end
    end

    assign RegWr_WB  = regwr_p1;
    assign Rd_WB     = rd_p1;
    assign RPzero_WB = rpzero_p1;
    assign WB_data   = wb_data_p1;
    assign mem_fault = fault_p1;
endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a word-array reference
// model with directed scenarios for store/load, kills, faults and reset.
`timescale 1ns/1ps
module tb_mem_stage;
    localparam int WORDS = 256;

    logic        clk;
    logic        reset;
    logic        RegWr_EX, MemWr_EX, MemRd_EX, RPzero_EX;
    logic [1:0]  WBdata_EX;
    logic [31:0] ALUout_EX, D, npc3;
    logic [3:0]  rd3;
    logic [31:0] Fwd_MEM, WB_data;
    logic        RegWr_WB, RPzero_WB, mem_fault;
    logic [3:0]  Rd_WB;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] ref_mem [WORDS];
    logic        ref_fault;

    mem_stage #(.DMEM_WORDS(256), .ADDR_BITS(8)) dut (
        .clk(clk), .reset(reset),
        .RegWr_EX(RegWr_EX), .MemWr_EX(MemWr_EX), .MemRd_EX(MemRd_EX),
        .WBdata_EX(WBdata_EX), .ALUout_EX(ALUout_EX), .D(D), .npc3(npc3),
        .rd3(rd3), .RPzero_EX(RPzero_EX),
        .Fwd_MEM(Fwd_MEM), .RegWr_WB(RegWr_WB), .Rd_WB(Rd_WB),
        .RPzero_WB(RPzero_WB), .WB_data(WB_data), .mem_fault(mem_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit addr_legal(input logic [31:0] a);
        return (a % 4 == 0) && (a < WORDS * 4);
    endfunction

    // Called at posedge+1; returns at the next posedge+1 with WB outputs checked.
    task automatic issue(input logic wr, input logic rd, input logic rw,
                         input logic [1:0] sel, input logic [31:0] alu,
                         input logic [31:0] d, input logic [31:0] npc,
                         input logic [3:0] dst, input logic kill);
        logic [31:0] e_ld, e_fwd;
        bit ok;
        MemWr_EX = wr; MemRd_EX = rd; RegWr_EX = rw; WBdata_EX = sel;
        ALUout_EX = alu; D = d; npc3 = npc; rd3 = dst; RPzero_EX = kill;
        ok   = addr_legal(alu);
        e_ld = (rd && !kill && ok) ? ref_mem[alu / 4] : 32'd0;
        case (sel)
            2'b01:   e_fwd = e_ld;
            2'b10:   e_fwd = npc;
            default: e_fwd = alu;
        endcase
        #4;
        check("fwd", Fwd_MEM, e_fwd);
        @(posedge clk);
        if (wr && !kill && ok) ref_mem[alu / 4] = d;
        if ((wr || rd) && !kill && !ok) ref_fault = 1'b1;
        #1;
        check("wb_data", WB_data, e_fwd);
        check("rd_wb", {28'd0, Rd_WB}, {28'd0, dst});
        check("regwr_wb", {31'd0, RegWr_WB}, {31'd0, rw & ~kill});
        check("rpzero_wb", {31'd0, RPzero_WB}, {31'd0, kill});
        check("fault", {31'd0, mem_fault}, {31'd0, ref_fault});
    endtask

    // Asserts reset between edges with a live store pending; returns at posedge+1.
    task automatic async_reset();
        MemWr_EX = 1'b1; MemRd_EX = 1'b0; RPzero_EX = 1'b0; RegWr_EX = 1'b1;
        WBdata_EX = 2'b00; ALUout_EX = 32'h10; D = 32'h0BAD_F00D; rd3 = 4'hF;
        reset = 1'b0;
        #1;
        ref_fault = 1'b0;
        check("rst_wb_data", WB_data, 32'd0);
        check("rst_rd_wb", {28'd0, Rd_WB}, 32'd0);
        check("rst_regwr", {31'd0, RegWr_WB}, 32'd0);
        check("rst_rpzero", {31'd0, RPzero_WB}, 32'd0);
        check("rst_fault", {31'd0, mem_fault}, 32'd0);
        @(posedge clk); #1;
        check("rst_hold_wb_data", WB_data, 32'd0);
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] a, v;
        int r;
        reset = 1'b0; ref_fault = 1'b0;
        RegWr_EX = 0; MemWr_EX = 0; MemRd_EX = 0; RPzero_EX = 0;
        WBdata_EX = 0; ALUout_EX = 0; D = 0; npc3 = 0; rd3 = 0;
        #1;
        check("init_wb_data", WB_data, 32'd0);
        check("init_fault", {31'd0, mem_fault}, 32'd0);
        check("init_regwr", {31'd0, RegWr_WB}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Fill every word so later loads have defined reference contents.
        for (int i = 0; i < WORDS; i++)
            issue(1, 0, 0, 2'($urandom_range(0, 3)), i * 4, $urandom, $urandom,
                  4'($urandom), 0);

        // Store then dependent load
        issue(1, 0, 0, 2'b00, 32'h10, 32'hDEADBEEF, 32'h0, 4'd0, 0);
        issue(0, 1, 1, 2'b01, 32'h10, 32'h0, 32'h0, 4'd5, 0);
        check("req034_data", WB_data, 32'hDEADBEEF);
        check("req034_rd", {28'd0, Rd_WB}, 32'd5);

        // Killed store must not land
        issue(1, 0, 1, 2'b00, 32'h10, 32'h1234, 32'h0, 4'd3, 1);
        check("kill_regwr", {31'd0, RegWr_WB}, 32'd0);
        issue(0, 1, 1, 2'b01, 32'h10, 32'h0, 32'h0, 4'd6, 0);
        check("kill_load", WB_data, 32'hDEADBEEF);
        check("kill_nofault", {31'd0, mem_fault}, 32'd0);

        // Store and load together return old contents
        issue(1, 1, 1, 2'b01, 32'h20, 32'hCAFE_0001, 32'h0, 4'd1, 0);
        issue(0, 1, 1, 2'b01, 32'h20, 32'h0, 32'h0, 4'd1, 0);
        check("same_cycle_new", WB_data, 32'hCAFE_0001);

        // NPC and reserved select
        issue(0, 0, 1, 2'b10, 32'h99, 32'h0, 32'h24, 4'd2, 0);
        check("npc_sel", WB_data, 32'h24);
        issue(0, 0, 1, 2'b11, 32'h7, 32'h0, 32'h24, 4'd2, 0);
        check("rsv_sel", WB_data, 32'h7);

        // Killed out-of-range load, then faulting loads
        issue(0, 1, 1, 2'b01, 32'h400, 32'h0, 32'h0, 4'd4, 1);
        check("kill_oor_nofault", {31'd0, mem_fault}, 32'd0);
        issue(0, 1, 1, 2'b01, 32'h400, 32'h0, 32'h0, 4'd4, 0);
        check("oor_fault", {31'd0, mem_fault}, 32'd1);
        check("oor_data", WB_data, 32'd0);
        issue(0, 1, 1, 2'b01, 32'h12, 32'h0, 32'h0, 4'd4, 0);
        check("misalign_data", WB_data, 32'd0);
        issue(0, 1, 1, 2'b01, 32'h10, 32'h0, 32'h0, 4'd4, 0);
        check("fault_sticky", {31'd0, mem_fault}, 32'd1);

        // Async reset with a pending store; memory must survive
        async_reset();
        issue(0, 1, 1, 2'b01, 32'h10, 32'h0, 32'h0, 4'd7, 0);
        check("post_rst_load", WB_data, 32'hDEADBEEF);

        // Randomized traffic with occasional faults and resets
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 19);
            if (r == 0)      a = {$urandom_range(0, WORDS - 1), 2'b00} | 32'($urandom_range(1, 3));
            else if (r == 1) a = $urandom | 32'h0000_0400;
            else             a = 32'($urandom_range(0, WORDS - 1)) * 4;
            v = $urandom;
            issue(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), a, v,
                  $urandom, 4'($urandom), ($urandom_range(0, 5) == 0));
            if (n % 150 == 149) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
